// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The byte-merge helper is used by the read-modify-write path.
package dmem_arb_pkg;

    localparam int DEPTH = 4096;
    localparam int IDX_W = 12;
    localparam logic [3:0] BE_FULL = 4'b1111;

    typedef enum logic {
        IDLE,
        MERGE
    } state_e;

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] index;
        logic [31:0]      wdata;
        logic [3:0]       be;
        logic             id;
    } req_t;

    // Enabled lanes come from the new data, the rest keep the old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_word & mask) | (old_word & ~mask);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit pointer.
// The pointer moves only on an accepted grant, and favours requester 0 after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q = 1 means requester 1 wins a tie.
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr_q);
        gnt1 = req1 & (~req0 | ptr_q);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer in front of the single-port data memory.
// Partial-word stores become a two-cycle read-modify-write because the memory has no byte enables.
module dmem_arbiter #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_be,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_be,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    import dmem_arb_pkg::*;

    state_e           state_q, state_d;
    req_t             merge_q, merge_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_load_q, rsp_load_d;
    logic [IDX_W-1:0] addr_q, addr_d;

    logic             arb_req0, arb_req1;
    logic             gnt0, gnt1;
    logic             accept;
    logic [31:0]      sel_addr;
    req_t             sel;
    logic             in_range;
    logic             is_full;
    logic             is_partial;
    logic [IDX_W-1:0] mem_idx;
    logic             rsp_live;
    logic [31:0]      rsp_data;
    logic             unused_bits;

    // Requests are only offered to the arbiter while idle and out of reset.
    always_comb begin
        arb_req0 = m0_req_valid & (state_q == IDLE) & ~rst;
        arb_req1 = m1_req_valid & (state_q == IDLE) & ~rst;
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (arb_req0),
        .req1   (arb_req1),
        .accept (accept),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    always_comb begin
        accept       = gnt0 | gnt1;
        m0_req_ready = gnt0;
        m1_req_ready = gnt1;
    end

    always_comb begin
        sel_addr   = gnt1 ? m1_req_addr  : m0_req_addr;
        sel.we     = gnt1 ? m1_req_we    : m0_req_we;
        sel.wdata  = gnt1 ? m1_req_wdata : m0_req_wdata;
        sel.be     = gnt1 ? m1_req_be    : m0_req_be;
        sel.id     = gnt1;
        sel.index  = sel_addr[IDX_W+1:2];
        in_range   = {2'b00, sel_addr[31:2]} < 32'(DEPTH);
        is_full    = sel.we & (sel.be == BE_FULL);
        is_partial = sel.we & (sel.be != BE_FULL) & (sel.be != 4'b0000);
    end

    assign unused_bits = ^{sel_addr[1:0], merge_q.we};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            merge_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
            addr_q      <= addr_d;
        end
    end

    // A partial store parks in MERGE for one cycle and acks from there instead of from IDLE.
    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = 1'b0;
        rsp_load_d  = 1'b0;
        if (state_q == MERGE) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = merge_q.id;
        end else if (accept) begin
            if (in_range && is_partial) begin
                state_d = MERGE;
                merge_d = sel;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = sel.id;
                rsp_err_d   = ~in_range;
                rsp_load_d  = in_range & ~sel.we;
            end
        end
    end

    // Memory port: the address holds its last value whenever nothing new is issued.
    always_comb begin
        mem_idx        = addr_q;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        if (state_q == MERGE) begin
            mem_idx        = merge_q.index;
            mem_write_en   = 1'b1;
            mem_write_data = merge_bytes(mem_read_data, merge_q.wdata, merge_q.be);
        end else if (accept && in_range) begin
            mem_idx        = sel.index;
            mem_write_en   = is_full;
            mem_write_data = sel.wdata;
        end
        if (rst) begin
            mem_idx      = '0;
            mem_write_en = 1'b0;
        end
        mem_addr = 32'(mem_idx);
        addr_d   = mem_idx;
    end

    // Load data is forwarded straight from the memory's registered read port.
    always_comb begin
        rsp_live     = rsp_valid_q & ~rst;
        rsp_data     = rsp_load_q ? mem_read_data : 32'h0;
        m0_rsp_valid = rsp_live & ~rsp_id_q;
        m1_rsp_valid = rsp_live & rsp_id_q;
        m0_rsp_rdata = m0_rsp_valid ? rsp_data : 32'h0;
        m1_rsp_rdata = m1_rsp_valid ? rsp_data : 32'h0;
        m0_rsp_err   = m0_rsp_valid & rsp_err_q;
        m1_rsp_err   = m1_rsp_valid & rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table plus randomized traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;

   localparam int NWORDS = 4096;
   localparam bit Y = 1'b1;
   localparam bit N = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m0_req_valid, m0_req_ready, m0_req_we;
   logic [31:0] m0_req_addr, m0_req_wdata;
   logic [3:0]  m0_req_be;
   logic        m0_rsp_valid, m0_rsp_err;
   logic [31:0] m0_rsp_rdata;
   logic        m1_req_valid, m1_req_ready, m1_req_we;
   logic [31:0] m1_req_addr, m1_req_wdata;
   logic [3:0]  m1_req_be;
   logic        m1_rsp_valid, m1_rsp_err;
   logic [31:0] m1_rsp_rdata;
   logic        mem_write_en;
   logic [31:0] mem_addr, mem_write_data;
   logic [31:0] mem_read_data = 32'h0;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .m0_req_valid   (m0_req_valid),
      .m0_req_ready   (m0_req_ready),
      .m0_req_we      (m0_req_we),
      .m0_req_addr    (m0_req_addr),
      .m0_req_wdata   (m0_req_wdata),
      .m0_req_be      (m0_req_be),
      .m0_rsp_valid   (m0_rsp_valid),
      .m0_rsp_rdata   (m0_rsp_rdata),
      .m0_rsp_err     (m0_rsp_err),
      .m1_req_valid   (m1_req_valid),
      .m1_req_ready   (m1_req_ready),
      .m1_req_we      (m1_req_we),
      .m1_req_addr    (m1_req_addr),
      .m1_req_wdata   (m1_req_wdata),
      .m1_req_be      (m1_req_be),
      .m1_rsp_valid   (m1_rsp_valid),
      .m1_rsp_rdata   (m1_rsp_rdata),
      .m1_rsp_err     (m1_rsp_err),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Single-port memory: registered read, read-before-write.
   logic [31:0] mem [NWORDS] = '{default: 32'h0};
   int badMemWrites = 0;
   always @(posedge clk) begin
      if (mem_addr < 32'(NWORDS)) mem_read_data <= mem[mem_addr[11:0]];
      else mem_read_data <= 32'h0;
      if (mem_write_en) begin
         if (mem_addr < 32'(NWORDS)) mem[mem_addr[11:0]] <= mem_write_data;
         else badMemWrites++;
      end
   end

   // Watchdog so the run always ends even if the bench itself stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      int          due;
      int          port;
      bit          err;
      logic [31:0] data;
   } rsp_t;

   rsp_t        rspQ[$];
   logic [31:0] shadow [NWORDS];
   int          cyc = 0;
   int          lastGnt = 1;
   bit          mergePending = 0;
   int          mIdx, mPort;
   logic [31:0] mWdata;
   logic [3:0]  mBe;

   int          predPort;
   bit          predWe;
   logic [31:0] predAddr, predData;
   logic [3:0]  predBe;
   bit          predWen, predAddrValid;
   logic [31:0] predMemAddr, predWdata;

   function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
      logic [31:0] r;
      r = oldW;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = newW[8*k +: 8];
      return r;
   endfunction

   function automatic bit inRange(input logic [31:0] a);
      return (a >> 2) < NWORDS;
   endfunction

   task automatic modelPredict();
      predPort = -1;
      predWen = 0;
      predAddrValid = 0;
      predMemAddr = 32'h0;
      predWdata = 32'h0;
      if (rst) begin
      end else if (mergePending) begin
         predWen = 1;
         predAddrValid = 1;
         predMemAddr = 32'(mIdx);
         predWdata = mergeWord(shadow[mIdx], mWdata, mBe);
      end else begin
         if (m0_req_valid && m1_req_valid) predPort = (lastGnt == 0) ? 1 : 0;
         else if (m0_req_valid) predPort = 0;
         else if (m1_req_valid) predPort = 1;
         if (predPort >= 0) begin
            predWe   = (predPort == 0) ? m0_req_we    : m1_req_we;
            predAddr = (predPort == 0) ? m0_req_addr  : m1_req_addr;
            predData = (predPort == 0) ? m0_req_wdata : m1_req_wdata;
            predBe   = (predPort == 0) ? m0_req_be    : m1_req_be;
            if (inRange(predAddr)) begin
               if (!predWe || predBe != 4'h0) begin
                  predAddrValid = 1;
                  predMemAddr = predAddr >> 2;
               end
               if (predWe && predBe == 4'hF) begin
                  predWen = 1;
                  predWdata = predData;
               end
            end
         end
      end
   endtask

   task automatic modelCheck();
      bit   e0, e1;
      rsp_t r;
      modelPredict();
      chk("m0_ready", 32'(m0_req_ready), 32'(predPort == 0));
      chk("m1_ready", 32'(m1_req_ready), 32'(predPort == 1));
      chk("mem_write_en", 32'(mem_write_en), 32'(predWen));
      if (predAddrValid) chk("mem_addr", mem_addr, predMemAddr);
      if (predWen) chk("mem_write_data", mem_write_data, predWdata);
      e0 = 0;
      e1 = 0;
      if (!rst && rspQ.size() > 0 && rspQ[0].due == cyc) begin
         r = rspQ[0];
         if (r.port == 0) e0 = 1; else e1 = 1;
      end
      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(e0));
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(e1));
      if (e0) begin
         chk("m0_rsp_err", 32'(m0_rsp_err), 32'(r.err));
         chk("m0_rsp_rdata", m0_rsp_rdata, r.data);
      end
      if (e1) begin
         chk("m1_rsp_err", 32'(m1_rsp_err), 32'(r.err));
         chk("m1_rsp_rdata", m1_rsp_rdata, r.data);
      end
   endtask

   task automatic modelAdvance();
      int idx;
      if (rst) begin
         lastGnt = 1;
         mergePending = 0;
      end else if (mergePending) begin
         shadow[mIdx] = predWdata;
         rspQ.push_back('{cyc + 1, mPort, 1'b0, 32'h0});
         mergePending = 0;
      end else if (predPort >= 0) begin
         lastGnt = predPort;
         idx = int'(predAddr >> 2);
         if (!inRange(predAddr)) begin
            rspQ.push_back('{cyc + 1, predPort, 1'b1, 32'h0});
         end else if (!predWe) begin
            rspQ.push_back('{cyc + 1, predPort, 1'b0, shadow[idx]});
         end else if (predBe == 4'hF) begin
            shadow[idx] = predData;
            rspQ.push_back('{cyc + 1, predPort, 1'b0, 32'h0});
         end else if (predBe == 4'h0) begin
            rspQ.push_back('{cyc + 1, predPort, 1'b0, 32'h0});
         end else begin
            mergePending = 1;
            mIdx = idx;
            mWdata = predData;
            mBe = predBe;
            mPort = predPort;
         end
      end
      while (rspQ.size() > 0 && rspQ[0].due <= cyc) void'(rspQ.pop_front());
      cyc++;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          rst;
      bit          v0;
      bit          we0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  be0;
      bit          v1;
      bit          we1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  be1;
      logic [1:0]  rdy;
      bit          wen;
      logic [31:0] wdata;
      logic [1:0]  rsp;
      bit          err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[27];

   task automatic applyStimulus(input vec_t v);
      rst          = v.rst;
      m0_req_valid = v.v0;
      m0_req_we    = v.we0;
      m0_req_addr  = v.a0;
      m0_req_wdata = v.d0;
      m0_req_be    = v.be0;
      m1_req_valid = v.v1;
      m1_req_we    = v.we1;
      m1_req_addr  = v.a1;
      m1_req_wdata = v.d1;
      m1_req_be    = v.be1;
   endtask

   task automatic checkOutput(input int row, input vec_t v);
      string tag;
      tag = $sformatf("row%0d", row);
      if (v.rst) chk({tag, " reset mem_addr"}, mem_addr, 32'h0);
      chk({tag, " m0_ready"}, 32'(m0_req_ready), 32'(v.rdy[0]));
      chk({tag, " m1_ready"}, 32'(m1_req_ready), 32'(v.rdy[1]));
      chk({tag, " mem_write_en"}, 32'(mem_write_en), 32'(v.wen));
      if (v.wen) chk({tag, " mem_write_data"}, mem_write_data, v.wdata);
      chk({tag, " m0_rsp_valid"}, 32'(m0_rsp_valid), 32'(v.rsp[0]));
      chk({tag, " m1_rsp_valid"}, 32'(m1_rsp_valid), 32'(v.rsp[1]));
      if (v.rsp[0]) begin
         chk({tag, " m0_rsp_err"}, 32'(m0_rsp_err), 32'(v.err));
         chk({tag, " m0_rsp_rdata"}, m0_rsp_rdata, v.rdata);
      end
      if (v.rsp[1]) begin
         chk({tag, " m1_rsp_err"}, 32'(m1_rsp_err), 32'(v.err));
         chk({tag, " m1_rsp_rdata"}, m1_rsp_rdata, v.rdata);
      end
   endtask

   // ---------------- random traffic state ----------------
   logic [31:0] pool [8] = '{32'h10, 32'h14, 32'h20, 32'h30, 32'h3FFC, 32'h4000, 32'h8000_0000, 32'h44};
   bit          rp [2];
   logic        rw [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];
   logic [3:0]  rb [2];

   initial begin
      for (int i = 0; i < NWORDS; i++) shadow[i] = 32'h0;
      rst = 1'b1;
      m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = 32'h0; m0_req_wdata = 32'h0; m0_req_be = 4'h0;
      m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = 32'h0; m1_req_wdata = 32'h0; m1_req_be = 4'h0;

      //           rst v0 we0 a0           d0            be0   v1 we1 a1         d1            be1   rdy    wen wdata         rsp    err rdata
      vecs[0]  = '{Y, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, N, 32'h0,        2'b00, N, 32'h0};
      vecs[1]  = '{N, Y, Y, 32'h10,    32'hDEADBEEF, 4'hF, N, N, 32'h0,    32'h0,        4'h0, 2'b01, Y, 32'hDEADBEEF, 2'b00, N, 32'h0};
      vecs[2]  = '{N, Y, N, 32'h10,    32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b01, N, 32'h0,        2'b01, N, 32'h0};
      vecs[3]  = '{N, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, N, 32'h0,        2'b01, N, 32'hDEADBEEF};
      vecs[4]  = '{N, Y, Y, 32'h20,    32'h11223344, 4'hF, N, N, 32'h0,    32'h0,        4'h0, 2'b01, Y, 32'h11223344, 2'b00, N, 32'h0};
      vecs[5]  = '{N, Y, Y, 32'h20,    32'hAABBCCDD, 4'h5, N, N, 32'h0,    32'h0,        4'h0, 2'b01, N, 32'h0,        2'b01, N, 32'h0};
      vecs[6]  = '{N, Y, N, 32'h20,    32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, Y, 32'h11BB33DD, 2'b00, N, 32'h0};
      vecs[7]  = '{N, Y, N, 32'h20,    32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b01, N, 32'h0,        2'b01, N, 32'h0};
      vecs[8]  = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b10, N, 32'h0,        2'b01, N, 32'h11BB33DD};
      vecs[9]  = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b01, N, 32'h0,        2'b10, N, 32'h11BB33DD};
      vecs[10] = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b10, N, 32'h0,        2'b01, N, 32'hDEADBEEF};
      vecs[11] = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b01, N, 32'h0,        2'b10, N, 32'h11BB33DD};
      vecs[12] = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b10, N, 32'h0,        2'b01, N, 32'hDEADBEEF};
      vecs[13] = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h20,   32'h0,        4'h0, 2'b01, N, 32'h0,        2'b10, N, 32'h11BB33DD};
      vecs[14] = '{N, Y, N, 32'h4000,  32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b01, N, 32'h0,        2'b01, N, 32'hDEADBEEF};
      vecs[15] = '{N, N, N, 32'h0,     32'h0,        4'h0, Y, Y, 32'h4000, 32'hFFFFFFFF, 4'hF, 2'b10, N, 32'h0,        2'b01, Y, 32'h0};
      vecs[16] = '{N, Y, Y, 32'h30,    32'h01020304, 4'hF, N, N, 32'h0,    32'h0,        4'h0, 2'b01, Y, 32'h01020304, 2'b10, Y, 32'h0};
      vecs[17] = '{N, Y, Y, 32'h30,    32'hA0B0C0D0, 4'h8, N, N, 32'h0,    32'h0,        4'h0, 2'b01, N, 32'h0,        2'b01, N, 32'h0};
      vecs[18] = '{N, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, Y, 32'hA0020304, 2'b00, N, 32'h0};
      vecs[19] = '{N, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, N, 32'h0,        2'b01, N, 32'h0};
      vecs[20] = '{N, N, N, 32'h0,     32'h0,        4'h0, Y, N, 32'h30,   32'h0,        4'h0, 2'b10, N, 32'h0,        2'b00, N, 32'h0};
      vecs[21] = '{N, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, N, 32'h0,        2'b10, N, 32'hA0020304};
      vecs[22] = '{N, N, N, 32'h0,     32'h0,        4'h0, Y, Y, 32'h10,   32'h55555555, 4'h3, 2'b10, N, 32'h0,        2'b00, N, 32'h0};
      vecs[23] = '{Y, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h10,   32'h0,        4'h0, 2'b00, N, 32'h0,        2'b00, N, 32'h0};
      vecs[24] = '{N, Y, N, 32'h10,    32'h0,        4'h0, Y, N, 32'h10,   32'h0,        4'h0, 2'b01, N, 32'h0,        2'b00, N, 32'h0};
      vecs[25] = '{N, N, N, 32'h0,     32'h0,        4'h0, Y, N, 32'h10,   32'h0,        4'h0, 2'b10, N, 32'h0,        2'b01, N, 32'hDEADBEEF};
      vecs[26] = '{N, N, N, 32'h0,     32'h0,        4'h0, N, N, 32'h0,    32'h0,        4'h0, 2'b00, N, 32'h0,        2'b10, N, 32'hDEADBEEF};

      $display("[TB] directed table: %0d rows", $size(vecs));
      for (int i = 0; i < $size(vecs); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(i, vecs[i]);
         modelCheck();
         @(posedge clk);
         modelAdvance();
         #1;
      end

      chk("word 0x10 after dropped RMW", mem[4], 32'hDEADBEEF);
      chk("word 0x30 after store+RMW", mem[12], 32'hA0020304);

      $display("[TB] randomized traffic");
      rp[0] = 0;
      rp[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rp[p] && ($urandom % 10) < 6) begin
               rp[p] = 1;
               rw[p] = 1'($urandom % 2);
               ra[p] = pool[$urandom % 8] | 32'($urandom % 4);
               rd[p] = $urandom;
               case ($urandom % 4)
                  0: rb[p] = 4'hF;
                  1: rb[p] = 4'h0;
                  default: rb[p] = 4'($urandom);
               endcase
            end
         end
         rst = (($urandom % 64) == 0);
         m0_req_valid = rp[0]; m0_req_we = rw[0]; m0_req_addr = ra[0]; m0_req_wdata = rd[0]; m0_req_be = rb[0];
         m1_req_valid = rp[1]; m1_req_we = rw[1]; m1_req_addr = ra[1]; m1_req_wdata = rd[1]; m1_req_be = rb[1];
         @(negedge clk);
         modelCheck();
         if (predPort >= 0) rp[predPort] = 0;
         @(posedge clk);
         modelAdvance();
         #1;
      end

      rst = 1'b0;
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         modelCheck();
         @(posedge clk);
         modelAdvance();
         #1;
      end

      for (int i = 0; i < 8; i++) begin
         if (inRange(pool[i])) chk($sformatf("final word %h", pool[i]), mem[pool[i][13:2]], shadow[pool[i][13:2]]);
      end
      chk("out-of-range memory writes", 32'(badMemWrites), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16 KB single-port data memory (32-bit words, 4096 entries, word-indexed, 1-cycle registered read, read-before-write).
- Requester 0 is the core load/store unit; requester 1 is the program/debug loader.
- Converts byte addresses to word indices and range-checks them.
- Implements partial-word stores as a read-modify-write, because the memory has no byte enables.

Parameters:
- DEPTH, 4096, number of 32-bit words in the memory.
- IDX_W, 12, width of the word index actually checked; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req_valid  in  1  request valid (N = 0, 1 for every mN_ port).
- mN_req_ready  out  1  request accepted this cycle when valid & ready.
- mN_req_we  in  1  1 = store, 0 = load.
- mN_req_addr  in  32  byte address; bits [1:0] ignored.
- mN_req_wdata  in  32  store data, byte lanes aligned to the word.
- mN_req_be  in  4  store byte enables; ignored for loads.
- mN_rsp_valid  out  1  one-cycle response pulse.
- mN_rsp_rdata  out  32  load data; 0 for stores and errors.
- mN_rsp_err  out  1  address out of range; qualified by rsp_valid.
- mem_write_en  out  1  to memory write_en.
- mem_addr  out  32  to memory addr (word index, zero-extended).
- mem_write_data  out  32  to memory write_data.
- mem_read_data  in  32  from memory read_data.

Behaviour:
- Reset: state IDLE, RR pointer favours m0, all rsp_valid 0, mem_write_en 0, mem_addr 0, ready 0.
  - mem_write_en is forced 0 in any cycle where rst = 1.
  - A pending response or an in-flight RMW is dropped; no write occurs.
- Handshake:
  - The requester holds valid and all request fields stable until ready.
  - ready is asserted only in IDLE, only to the granted requester, and only when rst = 0.
- Arbitration:
  - A single valid requester is granted.
  - When both are valid, the requester not granted at the last accepted handshake wins.
  - The pointer updates only on an accepted handshake.
- Index and range check: index = addr[31:2].
  - index >= DEPTH → no memory write.
  - rsp_valid rises the next cycle with err = 1 and rdata = 0.
- Load (accepted cycle N): mem_addr = index in N; at N+1, rsp_valid = 1 and rdata = mem_read_data, passed through combinationally.
- Full store (be = 4'b1111): mem_write_en = 1 in N; ack (rsp_valid = 1, rdata 0) at N+1.
- Store with be = 0: no memory write; ack at N+1.
- Partial store (be neither 0 nor 4'b1111), two-cycle RMW:
  - Cycle N: mem_addr = index, write_en = 0; go to MERGE, latching index, wdata, be and requester id.
  - Cycle N+1 (MERGE): ready low to both; mem_write_en = 1; mem_addr = latched index.
  - Merge rule: mem_write_data byte k = be[k] ? wdata byte k : mem_read_data byte k. Then go to IDLE.
  - Ack at N+2. The next request can be accepted at N+2.
- Throughput: one load or full store per cycle, back to back. A response for N and an acceptance at N+1 coexist.
- No hazards:
  - The memory write commits at the edge ending the write cycle, so any later read observes it.
  - An RMW read issued the cycle after a full store to the same word sees the new data.
- Idle with no request: mem_write_en 0; mem_addr holds its last value; the resulting read is harmless.
- Responses are returned in order, routed by the latched requester id; at most one rsp_valid is high per cycle.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, MERGE};
  - constants BE_FULL = 4'b1111, DEPTH = 4096, IDX_W = 12;
  - a request struct (we, index, wdata, be, id).
- Sub-module rr_arb2: a 2-way round-robin arbiter with a one-bit pointer, update-on-accept input, grant outputs and reset to favour m0.

Test Plan:
- Store 0xDEADBEEF (be = F) via m0 to addr 0x10, then load 0x10 → ack at N+1; load rsp rdata 0xDEADBEEF at next+1, err 0.
- Word at 0x20 = 0x11223344; partial store be = 4'b0101, wdata 0xAABBCCDD → m0_req_ready low in MERGE; mem_write_data 0x11BB33DD; ack at N+2; reload returns 0x11BB33DD.
- Both valid every cycle for 6 loads → grants alternate m0, m1, m0, …; each rsp_valid lands on the correct port one cycle after its accept.
- Load addr 0x4000 (index 4096) → no write; rsp_valid with err = 1, rdata 0; memory contents unchanged.
- Full store to 0x30 at cycle N, partial store be = 4'b1000 to 0x30 at N+1 → final word uses the new bytes [23:0] from the first store and byte 3 from the second.
- Assert rst during MERGE → mem_write_en 0 that cycle; no ack; ready 0; after release m0 is favoured; the target word is unchanged.
